// File: rtl/regfile_sb.sv
// Register file with combinational read ports, pending-producer scoreboard and a sequential soft-clear engine.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_vld,
    input  logic [ADDR_W-1:0]         issue_addr,
    input  logic                      wb_vld,
    input  logic [ADDR_W-1:0]         wb_addr,
    input  logic [DATA_W-1:0]         wb_data,
    input  logic [NREAD*ADDR_W-1:0]   raddr,
    output logic [NREAD*DATA_W-1:0]   rdata,
    output logic [NREAD-1:0]          rbusy,
    input  logic                      clr_start,
    output logic                      clr_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic [DEPTH-1:0]    pend_q, pend_d;
    logic                wb_en, iss_en;

    assign wb_en    = wb_vld && !((ZERO_REG != 0) && (wb_addr == '0));
    assign iss_en   = issue_vld && !((ZERO_REG != 0) && (issue_addr == '0));
    assign clr_busy = (state_q == CLEAR);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        pend_d  = pend_q;
        case (state_q)
            IDLE: begin
                if (wb_en)
                    mem_d[wb_addr] = wb_data;
                // Clear request wipes the scoreboard; an issue in the same cycle is lost.
                if (clr_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    pend_d  = '0;
                end else begin
                    if (wb_vld)
                        pend_d[wb_addr] = 1'b0;
                    if (iss_en)
                        pend_d[issue_addr] = 1'b1;
                end
            end
            CLEAR: begin
                mem_d[cnt_q] = '0;
                cnt_d        = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(DEPTH - 1))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            mem_q   <= mem_d;
        end
    end

    for (genvar g = 0; g < NREAD; g++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              zero, hit;
        logic [DATA_W-1:0] rd;
        logic              bsy;

        assign ra   = raddr[g*ADDR_W +: ADDR_W];
        assign zero = (ZERO_REG != 0) && (ra == '0);
        assign hit  = (state_q == IDLE) && wb_vld && (wb_addr == ra) && !zero;

        always_comb begin
            rd  = zero ? '0 : mem_q[ra];
            bsy = zero ? 1'b0 : pend_q[ra];
            if (state_q == CLEAR) begin
                bsy = 1'b1;
            end
`ifdef REGFILE_BYPASS_EN
            else if (hit) begin
                rd  = wb_data;
                bsy = 1'b0;
            end
`else
            // Without forwarding the consumer waits one cycle for the write to land.
            else if (hit) begin
                bsy = 1'b1;
            end
`endif
        end

        assign rdata[g*DATA_W +: DATA_W] = rd;
        assign rbusy[g]                  = bsy;
    end

endmodule
